bank_arbiter: RTL and testbench



---
 rtl/bank_arb_pkg.sv | 20 ++
 rtl/bank_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter.sv | 27 ++
 rtl/bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_bank_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_arb_pkg.sv
// rtl/bank_arb_pkg.sv - shared state type, error causes and index sizing for bank_arbiter
package bank_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int ERR_STRAY_CE  = 0;
    localparam int ERR_OVERFLOW  = 1;
    localparam int ERR_UNDERFLOW = 2;
    localparam int ERR_BAD_TAG   = 3;
    localparam int ERR_CAUSES    = 4;

    function automatic int idx_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/bank_arbiter_if.sv
// rtl/bank_arbiter_if.sv - requester and bank port bundle for bank_arbiter
interface bank_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 32,
    parameter int TAG_WIDTH     = 2,
    parameter int BE_WIDTH      = 16
) ();
    logic [NUM_REQ-1:0]               u_req;
    logic [NUM_REQ-1:0]               u_gnt;
    logic [NUM_REQ-1:0]               u_rdy;
    logic [NUM_REQ-1:0]               u_ce;
    logic [NUM_REQ-1:0]               u_w;
    logic [ADDRESS_WIDTH*NUM_REQ-1:0] u_a;
    logic [DATA_WIDTH*NUM_REQ-1:0]    u_d;
    logic [BE_WIDTH*NUM_REQ-1:0]      u_be;
    logic [NUM_REQ-1:0]               u_valid;
    logic [DATA_WIDTH-1:0]            u_q;
    logic                             m_ready;
    logic                             m_valid;
    logic [DATA_WIDTH-1:0]            m_q;
    logic [TAG_WIDTH-1:0]             m_qtag;
    logic                             m_req;
    logic                             m_ce;
    logic                             m_w;
    logic [ADDRESS_WIDTH-1:0]         m_a;
    logic [TAG_WIDTH-1:0]             m_tag;
    logic [DATA_WIDTH-1:0]            m_d;
    logic [BE_WIDTH-1:0]              m_be;

    modport master (
        input  u_req, u_ce, u_w, u_a, u_d, u_be, m_ready, m_valid, m_q, m_qtag,
        output u_gnt, u_rdy, u_valid, u_q, m_req, m_ce, m_w, m_a, m_tag, m_d, m_be
    );

    modport slave (
        output u_req, u_ce, u_w, u_a, u_d, u_be, m_ready, m_valid, m_q, m_qtag,
        input  u_gnt, u_rdy, u_valid, u_q, m_req, m_ce, m_w, m_a, m_tag, m_d, m_be
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after the last owner
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);
    // Scan from farthest to nearest so the closest requester after last overrides.
    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/bank_arbiter.sv
// rtl/bank_arbiter.sv - round-robin sharing of one bank port; BANK_ARB_QUANTUM_EN caps accesses per grant
module bank_arbiter
    import bank_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 32,
    parameter int TAG_WIDTH     = 2,
    parameter int BE_WIDTH      = 16,
    parameter int OUT_WIDTH     = 5
`ifdef BANK_ARB_QUANTUM_EN
    ,
    parameter int QUANTUM       = 64
`endif
) (
    input  logic           clk,
    input  logic           rst,
    bank_arbiter_if.master bus,
    output logic           busy,
    output logic           err
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        owner, last_owner, pick_idx;
    logic [NUM_REQ-1:0]      pick_gnt;
    logic                    own, owner_req, quantum_done, accept, rd_accept;
    logic [OUT_WIDTH-1:0]    outstanding;
    logic [ERR_CAUSES-1:0]   err_cause;
    logic [NUM_REQ-1:0]      route;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req  (bus.u_req),
        .last (last_owner),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign own = (state == ST_OWN);

`ifdef BANK_ARB_QUANTUM_EN
    localparam int QCNT_W = $clog2(QUANTUM + 1);
    logic [QCNT_W-1:0] qcount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               qcount <= '0;
        else if (state == ST_IDLE && |pick_gnt) qcount <= '0;
        else if (accept)                        qcount <= qcount + QCNT_W'(1);
    end

    assign quantum_done = own && (qcount == QCNT_W'(QUANTUM));
`else
    assign quantum_done = 1'b0;
`endif

    // Owner mux: everything toward the bank is zero unless a grant is held.
    always_comb begin
        bus.u_gnt = '0;
        bus.u_rdy = '0;
        bus.m_ce  = 1'b0;
        bus.m_w   = 1'b0;
        bus.m_a   = '0;
        bus.m_d   = '0;
        bus.m_be  = '0;
        owner_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own && owner == IDX_W'(i)) begin
                bus.u_gnt[i] = 1'b1;
                bus.u_rdy[i] = bus.m_ready & ~quantum_done;
                owner_req    = bus.u_req[i];
                bus.m_ce     = bus.u_ce[i] & ~quantum_done;
                bus.m_w      = bus.u_w[i];
                bus.m_a      = bus.u_a[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                bus.m_d      = bus.u_d[i*DATA_WIDTH +: DATA_WIDTH];
                bus.m_be     = bus.u_be[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    assign bus.m_req = own;
    assign bus.m_tag = TAG_WIDTH'(owner);
    assign accept    = bus.m_ce & bus.m_ready;
    assign rd_accept = accept & ~bus.m_w;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (|pick_gnt) state_n = ST_OWN;
            ST_OWN:     if (!owner_req || quantum_done) state_n = ST_RELEASE;
            ST_RELEASE: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            if (state == ST_IDLE && |pick_gnt) owner <= pick_idx;
            if (state == ST_RELEASE)           last_owner <= owner;
        end
    end

    always_comb begin
        route = '0;
        for (int i = 0; i < NUM_REQ; i++) route[i] = bus.m_valid && (int'(bus.m_qtag) == i);
    end

    always_comb begin
        err_cause                = '0;
        err_cause[ERR_STRAY_CE]  = |(bus.u_ce & ~bus.u_gnt);
        err_cause[ERR_OVERFLOW]  = rd_accept & ~bus.m_valid & (outstanding == OUT_MAX);
        err_cause[ERR_UNDERFLOW] = bus.m_valid & (outstanding == '0);
        err_cause[ERR_BAD_TAG]   = bus.m_valid & ~(int'(bus.m_qtag) < NUM_REQ);
    end

    // Simultaneous accept and return cancel; both ends saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            bus.u_valid <= '0;
            bus.u_q     <= '0;
            err         <= 1'b0;
        end else begin
            if (rd_accept && !bus.m_valid && outstanding != OUT_MAX)
                outstanding <= outstanding + OUT_WIDTH'(1);
            else if (!rd_accept && bus.m_valid && outstanding != '0)
                outstanding <= outstanding - OUT_WIDTH'(1);
            bus.u_valid <= route;
            if (|route) bus.u_q <= bus.m_q;
            err <= err | (|err_cause);
        end
    end

    assign busy = (state != ST_IDLE) | (outstanding != '0);

endmodule

// File: tb/tb_bank_arbiter.sv
// tb/tb_bank_arbiter.sv - randomized and directed self-checking bench for bank_arbiter
module tb_bank_arbiter;
    localparam int NR = 2, DW = 128, AW = 32, TW = 2, BW = 16, OW = 5;
    localparam int OUT_MAX = (1 << OW) - 1;
`ifdef BANK_ARB_QUANTUM_EN
    localparam int TB_QUANTUM = 4;
`endif

    logic clk, rst, busy, err;
    int checks = 0, errors = 0;

    bank_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                      .TAG_WIDTH(TW), .BE_WIDTH(BW)) bus ();

    bank_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TAG_WIDTH(TW),
                   .BE_WIDTH(BW), .OUT_WIDTH(OW)
`ifdef BANK_ARB_QUANTUM_EN
                   , .QUANTUM(TB_QUANTUM)
`endif
    ) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who holds the bank, a one-cycle cool-down after release, reads in flight.
    int holder = -1;
    bit cooling = 0;
    int last = NR - 1;
    int qcnt = 0;
    int outs = 0;
    logic [NR-1:0] exp_valid = '0;
    logic [DW-1:0] exp_q = '0;
    bit exp_err = 0;
    int bank_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit qdone();
`ifdef BANK_ARB_QUANTUM_EN
        return holder >= 0 && qcnt == TB_QUANTUM;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        bit g, qd, acc, rd;
        if (!rst) begin
            holder = -1; cooling = 0; last = NR - 1; qcnt = 0; outs = 0;
            exp_valid = '0; exp_q = '0; exp_err = 0;
            return;
        end
        g = holder >= 0;
        qd = qdone();
        acc = 0; rd = 0;
        if (g) begin
            acc = bus.u_ce[holder] && !qd && bus.m_ready;
            rd  = acc && !bus.u_w[holder];
        end
        for (int i = 0; i < NR; i++)
            if (bus.u_ce[i] && !(g && i == holder)) exp_err = 1;
        if (bus.m_valid && outs == 0) exp_err = 1;
        if (bus.m_valid && int'(bus.m_qtag) >= NR) exp_err = 1;
        if (rd && !bus.m_valid && outs == OUT_MAX) exp_err = 1;
        if (rd && !bus.m_valid && outs < OUT_MAX) outs++;
        else if (!rd && bus.m_valid && outs > 0) outs--;
        if (rd) bank_q.push_back(holder);
        exp_valid = '0;
        if (bus.m_valid && int'(bus.m_qtag) < NR) begin
            exp_valid[bus.m_qtag] = 1'b1;
            exp_q = bus.m_q;
        end
        if (g) begin
            if (acc) qcnt++;
            if (!bus.u_req[holder] || qd) begin
                last = holder; holder = -1; cooling = 1;
            end
        end else if (cooling) begin
            cooling = 0;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (last + k) % NR;
                if (bus.u_req[c] && holder < 0) begin holder = c; qcnt = 0; end
            end
        end
    endtask

    task automatic compare();
        logic [NR-1:0] one, eg, er;
        logic ce, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        bit g, qd;
        if (!rst) begin
            chk("reset_u_gnt", bus.u_gnt, 0);   chk("reset_u_rdy", bus.u_rdy, 0);
            chk("reset_u_valid", bus.u_valid, 0); chk("reset_u_q", bus.u_q, 0);
            chk("reset_m_req", bus.m_req, 0);   chk("reset_m_ce", bus.m_ce, 0);
            chk("reset_m_w", bus.m_w, 0);       chk("reset_m_a", bus.m_a, 0);
            chk("reset_m_tag", bus.m_tag, 0);   chk("reset_m_d", bus.m_d, 0);
            chk("reset_m_be", bus.m_be, 0);     chk("reset_busy", busy, 0);
            chk("reset_err", err, 0);
            return;
        end
        one = 1;
        g  = holder >= 0;
        qd = qdone();
        eg = g ? (one << holder) : '0;
        er = (g && bus.m_ready && !qd) ? eg : '0;
        ce = 0; w = 0; a = '0; d = '0; be = '0;
        if (g) begin
            ce = bus.u_ce[holder] && !qd;
            w  = bus.u_w[holder];
            a  = bus.u_a[holder*AW +: AW];
            d  = bus.u_d[holder*DW +: DW];
            be = bus.u_be[holder*BW +: BW];
            chk("m_tag", bus.m_tag, holder);
        end
        chk("u_gnt", bus.u_gnt, eg);   chk("u_rdy", bus.u_rdy, er);
        chk("m_req", bus.m_req, g);    chk("m_ce", bus.m_ce, ce);
        chk("m_w", bus.m_w, w);        chk("m_a", bus.m_a, a);
        chk("m_d", bus.m_d, d);        chk("m_be", bus.m_be, be);
        chk("u_valid", bus.u_valid, exp_valid);
        chk("u_q", bus.u_q, exp_q);
        chk("busy", busy, g || cooling || outs != 0);
        chk("err", err, exp_err);
    endtask

    always begin
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.u_req = '0; bus.u_ce = '0; bus.u_w = '0; bus.u_a = '0; bus.u_d = '0; bus.u_be = '0;
        bus.m_ready = 1'b0; bus.m_valid = 1'b0; bus.m_q = '0; bus.m_qtag = '0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        clear_inputs();
        bank_q.delete();
        step();
        step();
        rst = 1'b1;
    endtask

    int acc_cnt;

    initial begin
        rst = 1'b0;
        clear_inputs();
        do_reset();

        // Single requester: four reads, returned in order.
        step(); bus.u_req = 2'b01;
        neg();  chk("lit_grant_latency_pre", bus.u_gnt, 2'b00);
        step(); bus.u_ce = 2'b01; bus.u_w = 2'b00; bus.u_a[AW-1:0] = 32'h10; bus.m_ready = 1'b1;
        neg();  chk("lit_grant_0", bus.u_gnt, 2'b01); chk("lit_m_a_10", bus.m_a, 32'h10);
        for (int k = 1; k < 4; k++) begin
            step(); bus.u_a[AW-1:0] = 32'h10 + k;
            neg();  chk("lit_m_ce_read", bus.m_ce, 1);
        end
        step(); bus.u_ce = '0; bus.u_req = '0;
        for (int k = 0; k < 4; k++) begin
            step(); bus.m_valid = 1'b1; bus.m_qtag = 2'd0; bus.m_q = 128'hCAFE_0000 + k;
            neg();
            if (k > 0) begin
                chk("lit_ret_valid", bus.u_valid, 2'b01);
                chk("lit_ret_q", bus.u_q, 128'hCAFE_0000 + k - 1);
            end
            if (k == 3) chk("lit_busy_last_out", busy, 1);
        end
        step(); bus.m_valid = 1'b0;
        neg();  chk("lit_ret_q_last", bus.u_q, 128'hCAFE_0003); chk("lit_busy_done", busy, 0);

        // Contention: 0 first, handover in 3 cycles, 1 wins over a re-request from 0.
        do_reset();
        step(); bus.u_req = 2'b11;
        step(); bus.u_ce = 2'b01; bus.u_w = 2'b01; bus.m_ready = 1'b1;
        neg();  chk("lit_cont_first", bus.u_gnt, 2'b01);
        step(); step();
        step(); bus.u_ce = '0; bus.u_req = 2'b10;
        neg();  chk("lit_cont_drop_cycle", bus.u_gnt, 2'b01);
        step(); bus.u_req = 2'b11;
        neg();  chk("lit_cont_release", bus.u_gnt, 2'b00);
        step(); neg(); chk("lit_cont_idle", bus.u_gnt, 2'b00);
        step(); neg(); chk("lit_cont_second", bus.u_gnt, 2'b10);
        step(); bus.u_req = 2'b01;
        step(); step(); step();
        neg();  chk("lit_cont_back_to_0", bus.u_gnt, 2'b01);

        // Quantum: continuous ce from requester 0 while 1 also waits.
        do_reset();
        acc_cnt = 0;
        step(); bus.u_req = 2'b11; bus.m_ready = 1'b1; bus.u_w = 2'b01;
        for (int k = 0; k < 20; k++) begin
            step(); bus.u_ce = {1'b0, bus.u_gnt[0]};
            neg();  if (bus.m_ce && bus.m_ready) acc_cnt++;
        end
`ifdef BANK_ARB_QUANTUM_EN
        chk("lit_quantum_accepts", acc_cnt, TB_QUANTUM);
        chk("lit_quantum_handover", bus.u_gnt, 2'b10);
`else
        chk("lit_hold_accepts", acc_cnt, 20);
        chk("lit_hold_grant", bus.u_gnt, 2'b01);
`endif

        // Interleaved return: read by 0 comes back while 1 owns the bank.
        do_reset();
        step(); bus.u_req = 2'b01;
        step(); bus.u_ce = 2'b01; bus.u_a[AW-1:0] = 32'h40; bus.m_ready = 1'b1;
        step(); bus.u_ce = '0; bus.u_req = 2'b10;
        step(); step(); step();
        neg();  chk("lit_inter_owner1", bus.u_gnt, 2'b10);
        step(); bus.m_valid = 1'b1; bus.m_qtag = 2'd0; bus.m_q = 128'hBEEF; bus.u_req = '0;
        step(); bus.m_valid = 1'b0;
        neg();  chk("lit_inter_valid", bus.u_valid, 2'b01); chk("lit_inter_q", bus.u_q, 128'hBEEF);
        step(); neg(); chk("lit_inter_idle", busy, 0); chk("lit_inter_err", err, 0);

        // Error cases.
        do_reset();
        step(); bus.m_valid = 1'b1; bus.m_qtag = 2'd3; bus.m_q = 128'h1;
        step(); bus.m_valid = 1'b0;
        neg();  chk("lit_badtag_valid", bus.u_valid, 2'b00); chk("lit_badtag_err", err, 1);
        do_reset();
        step(); bus.m_valid = 1'b1; bus.m_qtag = 2'd0; bus.m_q = 128'h55;
        step(); bus.m_valid = 1'b0;
        neg();  chk("lit_under_valid", bus.u_valid, 2'b01); chk("lit_under_err", err, 1);
        do_reset();
        step(); bus.u_ce = 2'b10;
        step(); bus.u_ce = '0;
        neg();  chk("lit_stray_err", err, 1);

        // Reset mid-burst.
        do_reset();
        step(); bus.u_req = 2'b01;
        step(); bus.u_ce = 2'b01; bus.u_a[AW-1:0] = 32'h77; bus.m_ready = 1'b1;
        neg();  chk("lit_burst_ce", bus.m_ce, 1);
        step(); rst = 1'b0;
        neg();  chk("lit_midrst_gnt", bus.u_gnt, 0); chk("lit_midrst_ce", bus.m_ce, 0);
        chk("lit_midrst_a", bus.m_a, 0);
        step(); rst = 1'b1; bus.u_ce = '0; bus.u_req = 2'b11;
        step(); neg(); chk("lit_after_rst_gnt", bus.u_gnt, 2'b01);

        // Randomized traffic with a bank that returns reads in issue order.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            bus.m_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NR; i++) begin
                if ($urandom % 8 == 0) bus.u_req[i] = ~bus.u_req[i];
                bus.u_ce[i] = bus.u_gnt[i] && bus.m_ready && ($urandom % 4 != 0);
                bus.u_w[i]  = $urandom % 2;
            end
            for (int b = 0; b < AW*NR; b += 32) bus.u_a[b +: 32] = $urandom;
            for (int b = 0; b < DW*NR; b += 32) bus.u_d[b +: 32] = $urandom;
            bus.u_be = $urandom;
            for (int b = 0; b < DW; b += 32) bus.m_q[b +: 32] = $urandom;
            if (bank_q.size() > 0 && ($urandom % 2 == 0)) begin
                bus.m_valid = 1'b1;
                bus.m_qtag  = TW'(bank_q.pop_front());
            end else begin
                bus.m_valid = 1'b0;
                bus.m_qtag  = TW'($urandom);
            end
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
